// File: rtl/mux61_stream_ctrl.sv
// Operand stager and select sequencer for the 32-bit 6:1 operand mux.
// One load captures six words; sel then steps once per accepted output transfer.
module mux61_stream_ctrl #(
  parameter int         WIDTH    = 32,
  parameter int         MAXW     = 6,
  parameter logic [2:0] IDLE_SEL = 3'b111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] ld_a,
  input  logic [WIDTH-1:0] ld_b,
  input  logic [WIDTH-1:0] ld_c,
  input  logic [WIDTH-1:0] ld_d,
  input  logic [WIDTH-1:0] ld_e,
  input  logic [WIDTH-1:0] ld_f,
  input  logic [2:0]       ld_cnt,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             last,
  output logic             done
);

  // state  | meaning
  // IDLE   | ld_ready high, sel parked at IDLE_SEL, waiting for a load
  // STREAM | operands held, sel walks 0..cnt-1 one word per transfer
  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [2:0] MAXW3 = 3'(MAXW);

  state_t     state;
  logic [2:0] cnt;
  logic [2:0] cnt_n;
  logic [2:0] sel_inc;

  // A count of 0 or anything past the slot count means "all slots".
  assign cnt_n   = (ld_cnt == 3'd0 || ld_cnt > MAXW3) ? MAXW3 : ld_cnt;
  assign sel_inc = sel + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= MAXW3;
      sel       <= IDLE_SEL;
      out_valid <= 1'b0;
      last      <= 1'b0;
      done      <= 1'b0;
      ld_ready  <= 1'b1;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      e         <= '0;
      f         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_valid && ld_ready) begin
            a         <= ld_a;
            b         <= ld_b;
            c         <= ld_c;
            d         <= ld_d;
            e         <= ld_e;
            f         <= ld_f;
            cnt       <= cnt_n;
            sel       <= 3'd0;
            out_valid <= 1'b1;
            last      <= (cnt_n == 3'd1);
            ld_ready  <= 1'b0;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (out_valid && out_ready) begin
            if (last) begin
              sel       <= IDLE_SEL;
              out_valid <= 1'b0;
              last      <= 1'b0;
              done      <= 1'b1;
              ld_ready  <= 1'b1;
              state     <= IDLE;
            end else begin
              sel  <= sel_inc;
              last <= (sel_inc == cnt - 3'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux61_stream_ctrl.sv
// Self-checking bench for mux61_stream_ctrl: vector table of loads plus
// hand-written corner sequences, with a scoreboard of expected output beats.
module tb_mux61_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_a, ld_b, ld_c, ld_d, ld_e, ld_f;
  logic [2:0]  ld_cnt;
  logic [31:0] a, b, c, d, e, f;
  logic [2:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic        last;
  logic        done;

  mux61_stream_ctrl #(.WIDTH(32), .MAXW(6), .IDLE_SEL(3'b111)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_a(ld_a), .ld_b(ld_b), .ld_c(ld_c), .ld_d(ld_d), .ld_e(ld_e), .ld_f(ld_f),
    .ld_cnt(ld_cnt),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .last(last), .done(done)
  );

  always #5 clk = ~clk;

  typedef logic [31:0] words_t [6];
  typedef struct {
    logic [2:0]  sel;
    logic [31:0] data;
    logic        last;
  } exp_t;
  typedef struct {
    logic [2:0] cnt;
    int         exp_n;
    bit         bp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   ncmp = 0;
  int   nerr = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] slot(input logic [2:0] s);
    case (s)
      3'd0: return a;
      3'd1: return b;
      3'd2: return c;
      3'd3: return d;
      3'd4: return e;
      3'd5: return f;
      default: return 32'hdead_beef;
    endcase
  endfunction

  // Consume the beat currently on the outputs (caller holds out_ready=1 across the edge).
  task automatic take_beat(output bit was_last);
    exp_t x;
    was_last = 1'b0;
    if (sb.size() == 0) begin
      ncmp++; nerr++;
      $display("FAIL sb_empty: unexpected beat sel=%0d", sel);
    end else begin
      x = sb.pop_front();
      check("beat_sel", {29'd0, sel}, {29'd0, x.sel});
      check("beat_data", slot(sel), x.data);
      check("beat_last", {31'd0, last}, {31'd0, x.last});
      was_last = x.last;
    end
  endtask

  task automatic do_load(input logic [2:0] cn, input words_t w);
    int n;
    int guard = 0;
    while (!ld_ready && guard < 50) begin
      step();
      guard++;
    end
    if (!ld_ready) begin
      ncmp++; nerr++;
      $display("FAIL load_wait: ld_ready=%0b expected 1", ld_ready);
    end
    n = (cn == 3'd0 || cn == 3'd7) ? 6 : int'(cn);
    ld_a = w[0]; ld_b = w[1]; ld_c = w[2]; ld_d = w[3]; ld_e = w[4]; ld_f = w[5];
    ld_cnt = cn;
    ld_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_t x;
      x.sel = 3'(i);
      x.data = w[i];
      x.last = (i == n - 1);
      sb.push_back(x);
    end
    step();
    ld_valid = 1'b0;
    check("load_sel0", {29'd0, sel}, 32'd0);
    check("load_valid", {31'd0, out_valid}, 32'd1);
    check("load_ready_low", {31'd0, ld_ready}, 32'd0);
    check("load_a", a, w[0]);
    check("load_f", f, w[5]);
  endtask

  task automatic run_burst(input bit bp, output int beats);
    bit fin = 1'b0;
    bit wl;
    int guard = 0;
    beats = 0;
    while (!fin && guard < 300) begin
      guard++;
      if (!out_valid) begin
        ncmp++; nerr++;
        $display("FAIL stream_valid: out_valid=0 mid-burst expected 1");
        guard = 300;
      end else begin
        check("stream_done_low", {31'd0, done}, 32'd0);
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) begin
          take_beat(wl);
          beats++;
          fin = wl;
        end
        step();
      end
    end
    out_ready = 1'b0;
    if (!fin) begin
      ncmp++; nerr++;
      $display("FAIL burst_timeout: beats=%0d burst did not complete", beats);
    end else begin
      check("end_done", {31'd0, done}, 32'd1);
      check("end_valid", {31'd0, out_valid}, 32'd0);
      check("end_sel", {29'd0, sel}, 32'd7);
      check("end_ready", {31'd0, ld_ready}, 32'd1);
      check("end_last", {31'd0, last}, 32'd0);
    end
  endtask

  function automatic words_t rand_words();
    words_t w;
    for (int i = 0; i < 6; i++) w[i] = $urandom;
    return w;
  endfunction

  initial begin
    words_t w;
    words_t w2;
    int beats;
    bit wl;

    vecs[0] = '{cnt: 3'd1, exp_n: 1, bp: 1'b0};
    vecs[1] = '{cnt: 3'd2, exp_n: 2, bp: 1'b1};
    vecs[2] = '{cnt: 3'd3, exp_n: 3, bp: 1'b0};
    vecs[3] = '{cnt: 3'd4, exp_n: 4, bp: 1'b1};
    vecs[4] = '{cnt: 3'd5, exp_n: 5, bp: 1'b1};
    vecs[5] = '{cnt: 3'd6, exp_n: 6, bp: 1'b0};
    vecs[6] = '{cnt: 3'd0, exp_n: 6, bp: 1'b1};
    vecs[7] = '{cnt: 3'd7, exp_n: 6, bp: 1'b0};

    rst = 1'b1; ld_valid = 1'b0; out_ready = 1'b0; ld_cnt = 3'd0;
    ld_a = '0; ld_b = '0; ld_c = '0; ld_d = '0; ld_e = '0; ld_f = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_sel", {29'd0, sel}, 32'd7);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, ld_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_last", {31'd0, last}, 32'd0);
    check("rst_slots", a | b | c | d | e | f, 32'd0);

    // Full burst, consumer always ready
    w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666};
    do_load(3'd6, w);
    run_burst(1'b0, beats);
    check("full_beats", beats, 32'd6);
    step();
    check("full_done_once", {31'd0, done}, 32'd0);
    check("full_hold_a", a, 32'h11111111);

    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].cnt, rand_words());
      run_burst(vecs[i].bp, beats);
      check("vec_beats", beats, vecs[i].exp_n);
      step();
    end

    // Short burst with backpressure at sel=1
    w = rand_words();
    do_load(3'd3, w);
    out_ready = 1'b1;
    take_beat(wl);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("bp_hold_sel", {29'd0, sel}, 32'd1);
      check("bp_hold_last", {31'd0, last}, 32'd0);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      step();
    end
    check("bp_sel_still1", {29'd0, sel}, 32'd1);
    run_burst(1'b0, beats);
    check("bp_beats", beats, 32'd2);
    step();
    check("bp_done_once", {31'd0, done}, 32'd0);

    // Count 0 normalised; a load request mid-burst is ignored
    w = rand_words();
    w2 = rand_words();
    do_load(3'd0, w);
    ld_a = w2[0]; ld_b = w2[1]; ld_c = w2[2]; ld_d = w2[3]; ld_e = w2[4]; ld_f = w2[5];
    ld_cnt = 3'd1;
    ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ign_ready", {31'd0, ld_ready}, 32'd0);
      check("ign_a", a, w[0]);
      check("ign_f", f, w[5]);
      check("ign_sel", {29'd0, sel}, 32'd0);
    end
    ld_valid = 1'b0;
    run_burst(1'b1, beats);
    check("ign_beats", beats, 32'd6);
    check("ign_c", c, w[2]);

    // Back-to-back: new load in the done cycle
    w2 = rand_words();
    do_load(3'd1, w2);
    check("b2b_last", {31'd0, last}, 32'd1);
    check("b2b_done_low", {31'd0, done}, 32'd0);
    run_burst(1'b0, beats);
    check("b2b_beats", beats, 32'd1);
    step();

    // Reset mid-burst at sel=2
    do_load(3'd6, rand_words());
    out_ready = 1'b1;
    take_beat(wl);
    step();
    take_beat(wl);
    step();
    out_ready = 1'b0;
    check("mid_sel2", {29'd0, sel}, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    check("mid_sel", {29'd0, sel}, 32'd7);
    check("mid_valid", {31'd0, out_valid}, 32'd0);
    check("mid_ready", {31'd0, ld_ready}, 32'd1);
    check("mid_last", {31'd0, last}, 32'd0);
    check("mid_slots", a | b | c | d | e | f, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("mid_no_done", {31'd0, done}, 32'd0);
      step();
    end

    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/mux61_stream_ctrl.md
Name: mux61_stream_ctrl

Overview:
Upstream operand stager and select sequencer for the 32-bit 6:1 operand mux in the modular-division datapath. It captures up to six 32-bit operand words in one load handshake and holds them on the mux's six data inputs. It then steps the 3-bit select one word per accepted transfer, with a valid/ready handshake toward the consumer.

Parameters:
WIDTH, 32, width of each operand word and of each mux data input
MAXW, 6, number of operand slots (fixed to match the 6:1 mux; sel codes 0..5)
IDLE_SEL, 3'b111, select code driven when not streaming (mux default branch, outputs zero)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
ld_valid  input  1  load request, operand words and count valid
ld_ready  output  1  block can accept a load
ld_a  input  WIDTH  operand word for slot 0
ld_b  input  WIDTH  operand word for slot 1
ld_c  input  WIDTH  operand word for slot 2
ld_d  input  WIDTH  operand word for slot 3
ld_e  input  WIDTH  operand word for slot 4
ld_f  input  WIDTH  operand word for slot 5
ld_cnt  input  3  number of words to stream (1..6; 0 or 7 treated as 6)
a  output  WIDTH  held operand slot 0 to mux
b  output  WIDTH  held operand slot 1 to mux
c  output  WIDTH  held operand slot 2 to mux
d  output  WIDTH  held operand slot 3 to mux
e  output  WIDTH  held operand slot 4 to mux
f  output  WIDTH  held operand slot 5 to mux
sel  output  3  mux select, registered
out_valid  output  1  mux output word is valid
out_ready  input  1  consumer accepts current word
last  output  1  current word is the final one of the burst
done  output  1  one-cycle pulse after the final word is accepted

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high. All outputs are registered.
- Reset values:
  - state IDLE, sel=IDLE_SEL, a..f=0, out_valid=0, last=0, done=0.
  - ld_ready=1, and cnt register=6.
- States are IDLE and STREAM.
- IDLE:
  - ld_ready=1, out_valid=0, sel=IDLE_SEL.
  - A load is accepted when ld_valid=1 and ld_ready=1. On acceptance, the next edge latches ld_a..ld_f into a..f and latches the normalised count into cnt.
  - On that same edge: sel<=0, out_valid<=1, last<=(cnt==1), ld_ready<=0, and the state moves to STREAM.
  - Latency: word 0 is presented on the mux output in the first cycle after acceptance.
- STREAM:
  - out_valid=1 and ld_ready=0. ld_valid is ignored and the load inputs are not sampled.
  - A transfer occurs when out_valid=1 and out_ready=1.
  - Transfer with last=0: sel<=sel+1, and last<=(sel+1==cnt-1).
  - Transfer with last=1: sel<=IDLE_SEL, out_valid<=0, last<=0, done<=1 for exactly one cycle, ld_ready<=1, state<=IDLE.
  - out_ready=0: sel, out_valid and last hold. There is no timeout.
- After the final transfer, a new load may be accepted in the same cycle done is high. Minimum gap between bursts is one cycle.
- a..f keep their values after done until the next accepted load; they are not cleared.
- Word order is always slot 0 upward. Slots at or above cnt are captured but never selected.
- sel never takes values 6 or 7 except IDLE_SEL while idle.
- Reset mid-burst aborts immediately to the reset values. No done pulse is produced, and the partial burst is discarded.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst for 2 cycles.
  - Required: sel=3'b111, out_valid=0, ld_ready=1, a..f=0, done=0.
- Full burst, consumer always ready:
  - Stimulus: load ld_a..ld_f=32'h11111111..32'h66666666 with ld_cnt=6, out_ready=1.
  - Required: sel goes 0,1,2,3,4,5 on consecutive cycles starting the cycle after load. last=1 only at sel=5. done pulses the next cycle, sel returns to 7, and ld_ready=1.
- Short burst with backpressure:
  - Stimulus: ld_cnt=3, out_ready low for 2 cycles at sel=1.
  - Required: sel holds at 1 for 3 cycles, then advances to 2 with last=1. done pulses once. Slots d..f are never selected.
- Count normalisation and load ignored in STREAM:
  - Stimulus: ld_cnt=0, then a second ld_valid with different data during the burst.
  - Required: 6 words are streamed, a..f are unchanged by the second request, and ld_ready stays 0 until done.
- Back-to-back bursts:
  - Stimulus: assert ld_valid in the done cycle with new data and ld_cnt=1.
  - Required: load accepted. Next cycle sel=0, last=1, a=new word. done follows the single transfer.
- Reset mid-burst:
  - Stimulus: assert rst at sel=2 of a 6-word burst.
  - Required: next cycle shows all reset values, and no done pulse appears.
